// File: rtl/led7_scan_ctrl_pkg.sv
// rtl/led7_scan_ctrl_pkg.sv - shared display constants and types for the scan controller
package led7_scan_ctrl_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  typedef enum logic {SLOT_GUARD, SLOT_DRIVE} slot_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  en;
    logic [3:0]  mask;
  } disp_cfg_t;
endpackage

// File: rtl/led7_decoder.sv
// rtl/led7_decoder.sv - hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}
module led7_decoder
  import led7_scan_ctrl_pkg::*;
(
  input  logic       i_en,
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_en) begin
      case (i_nibble)
        4'h0: o_seg = 7'b1000000;
        4'h1: o_seg = 7'b1111001;
        4'h2: o_seg = 7'b0100100;
        4'h3: o_seg = 7'b0110000;
        4'h4: o_seg = 7'b0011001;
        4'h5: o_seg = 7'b0010010;
        4'h6: o_seg = 7'b0000010;
        4'h7: o_seg = 7'b1111000;
        4'h8: o_seg = 7'b0000000;
        4'h9: o_seg = 7'b0010000;
        4'hA: o_seg = 7'b0001000;
        4'hB: o_seg = 7'b0000011;
        4'hC: o_seg = 7'b1000110;
        4'hD: o_seg = 7'b0100001;
        4'hE: o_seg = 7'b0000110;
        default: o_seg = 7'b0001110;
      endcase
    end
  end

endmodule

// File: rtl/led7_scan_ctrl.sv
// rtl/led7_scan_ctrl.sv - 4-digit multiplexed 7-segment scanner with guard blanking,
// per-digit blink and scan-aligned double-buffered loads
module led7_scan_ctrl
  import led7_scan_ctrl_pkg::*;
#(
  parameter int CLK_PER_DIGIT = 100000,
  parameter int GUARD_CYCLES  = 1000,
  parameter int BLINK_SCANS   = 125
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_digit_en,
  input  logic [3:0]  i_blink_mask,
  input  logic        i_load,
  output logic [3:0]  o_anode,
  output logic [6:0]  o_7seg,
  output logic        o_scan_done,
  output logic        o_load_ack
);

  localparam int CNT_W  = $clog2(CLK_PER_DIGIT);
  localparam int SCAN_W = $clog2(BLINK_SCANS + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dig_q, dig_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              phase_q, phase_d;
  logic              pend_flag_q, pend_flag_d;
  disp_cfg_t         pend_q, pend_d;
  disp_cfg_t         act_q, act_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              scan_done_q, scan_done_d;
  logic              load_ack_q, load_ack_d;

  slot_t      slot;
  logic       slot_end;
  logic       wrap;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  assign slot     = (cnt_q < CNT_W'(GUARD_CYCLES)) ? SLOT_GUARD : SLOT_DRIVE;
  assign slot_end = (cnt_q == CNT_W'(CLK_PER_DIGIT - 1));
  assign wrap     = slot_end && (dig_q == 2'd3);
  assign nibble   = act_q.digits[{dig_q, 2'b00} +: 4];
  assign lit      = act_q.en[dig_q] && !(phase_q && act_q.mask[dig_q]);

  led7_decoder u_decoder (
    .i_en     (1'b1),
    .i_nibble (nibble),
    .o_seg    (dec_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      scan_q      <= '0;
      phase_q     <= 1'b0;
      pend_flag_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      anode_q     <= ANODE_OFF;
      seg_q       <= SEG_BLANK;
      scan_done_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      scan_q      <= scan_d;
      phase_q     <= phase_d;
      pend_flag_q <= pend_flag_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      scan_done_q <= scan_done_d;
      load_ack_q  <= load_ack_d;
    end
  end

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
    dig_d       = slot_end ? dig_q + 2'd1 : dig_q;
    scan_d      = scan_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    act_d       = act_q;
    if (wrap) begin
      if (scan_q == SCAN_W'(BLINK_SCANS - 1)) begin
        scan_d  = '0;
        phase_d = ~phase_q;
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
      if (pend_flag_q) begin
        act_d       = pend_q;
        pend_flag_d = 1'b0;
      end
    end
    // A load landing on the wrap cycle re-arms pending for the next wrap
    if (i_load) begin
      pend_d      = '{digits: i_digits, en: i_digit_en, mask: i_blink_mask};
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    anode_d     = ANODE_OFF;
    seg_d       = SEG_BLANK;
    scan_done_d = wrap;
    load_ack_d  = wrap && pend_flag_q;
    if (slot == SLOT_DRIVE && lit) begin
      anode_d[dig_q] = 1'b0;
      seg_d          = dec_seg;
    end
  end

  assign o_anode     = anode_q;
  assign o_7seg      = seg_q;
  assign o_scan_done = scan_done_q;
  assign o_load_ack  = load_ack_q;

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// tb/tb_led7_scan_ctrl.sv - directed self-checking bench for led7_scan_ctrl
module tb_led7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic        load;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        scan_done;
  logic        load_ack;

  int checks   = 0;
  int failures = 0;

  localparam logic [27:0] S_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] S_ABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
  localparam logic [27:0] S_NONE = {4{7'b1111111}};

  led7_scan_ctrl #(
    .CLK_PER_DIGIT (8),
    .GUARD_CYCLES  (2),
    .BLINK_SCANS   (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_digits     (digits),
    .i_digit_en   (digit_en),
    .i_blink_mask (blink_mask),
    .i_load       (load),
    .o_anode      (anode),
    .o_7seg       (seg),
    .o_scan_done  (scan_done),
    .o_load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, "_an"},   32'(anode),     32'hF);
    check_eq({tag, "_seg"},  32'(seg),       32'h7F);
    check_eq({tag, "_done"}, 32'(scan_done), 32'h0);
    check_eq({tag, "_ack"},  32'(load_ack),  32'h0);
  endtask

  // Sample j reflects scan state j (dig=j/8, cnt=j%8); guard is cnt 0..1.
  task automatic check_scan(input int scan_no, input logic [3:0] on, input logic [27:0] segs,
                            input logic ack_exp, input int load_at, input int last_j);
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    for (int j = 0; j <= last_j; j++) begin
      load = (j == load_at);
      tick();
      exp_an = 4'hF;
      exp_sg = 7'h7F;
      if ((j % 8) >= 2 && on[j / 8]) begin
        exp_an[j / 8] = 1'b0;
        exp_sg        = segs[7 * (j / 8) +: 7];
      end
      check_eq($sformatf("s%0d_j%0d_an", scan_no, j),   32'(anode),     32'(exp_an));
      check_eq($sformatf("s%0d_j%0d_seg", scan_no, j),  32'(seg),       32'(exp_sg));
      check_eq($sformatf("s%0d_j%0d_done", scan_no, j), 32'(scan_done), 32'(j == 31));
      check_eq($sformatf("s%0d_j%0d_ack", scan_no, j),  32'(load_ack),
               32'((j == 31) ? ack_exp : 1'b0));
    end
    load = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    digits     = 16'h0;
    digit_en   = 4'h0;
    blink_mask = 4'h0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check_blank($sformatf("rst%0d", i));
    end
    rst = 1'b0;

    digits = 16'h1234; digit_en = 4'b1111; blink_mask = 4'b0000;
    check_scan(1, 4'b0000, S_NONE, 1'b1, 0, 31);
    digit_en = 4'b1011;
    check_scan(2, 4'b1111, S_1234, 1'b1, 5, 31);
    digit_en = 4'b1111; blink_mask = 4'b0001;
    check_scan(3, 4'b1011, S_1234, 1'b1, 5, 31);
    check_scan(4, 4'b1110, S_1234, 1'b0, -1, 31);
    check_scan(5, 4'b1111, S_1234, 1'b0, -1, 31);
    check_scan(6, 4'b1111, S_1234, 1'b0, -1, 31);
    check_scan(7, 4'b1110, S_1234, 1'b0, -1, 31);
    digits = 16'hABCD; blink_mask = 4'b0000;
    check_scan(8, 4'b1110, S_1234, 1'b0, 31, 31);
    check_scan(9, 4'b1111, S_1234, 1'b1, -1, 31);
    digits = 16'hFFFF;
    check_scan(10, 4'b1111, S_ABCD, 1'b0, 3, 20);

    rst = 1'b1;
    tick();
    check_blank("mid_rst0");
    tick();
    check_blank("mid_rst1");
    rst = 1'b0;
    check_scan(11, 4'b0000, S_NONE, 1'b0, -1, 31);
    check_scan(12, 4'b0000, S_NONE, 1'b0, -1, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led7_scan_ctrl.md
LED7_SCAN_CTRL -- requirements
Module: led7_scan_ctrl

Interface
REQ-001 Parameter CLK_PER_DIGIT, default 100000: clock cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter GUARD_CYCLES, default 1000: blanked cycles at the start of each slot; legal range is 1 to CLK_PER_DIGIT-1.
REQ-003 Parameter BLINK_SCANS, default 125: full 4-digit scans per blink half-period; legal range is 1 or more.
REQ-004 i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_digits  in  16  four hex nibbles; digit k = i_digits[4k+3:4k].
REQ-007 i_digit_en  in  4  per-digit enable; 1 = digit shown.
REQ-008 i_blink_mask  in  4  per-digit blink select.
REQ-009 i_load  in  1  one-cycle strobe that captures i_digits, i_digit_en and i_blink_mask.
REQ-010 o_anode  out  4  active-low digit select; bit k drives digit k.
REQ-011 o_7seg  out  7  active-low segments, same encoding as led7_decoder.
REQ-012 o_scan_done  out  1  one-cycle pulse at each scan wrap.
REQ-013 o_load_ack  out  1  one-cycle pulse when pending data becomes active.

Function
REQ-014 The block SHALL keep the slot counter cnt (0..CLK_PER_DIGIT-1) and the digit index dig (0..3); at cnt=CLK_PER_DIGIT-1, cnt SHALL go to 0 and dig SHALL increment, wrapping from 3 to 0.
REQ-015 The slot state SHALL be GUARD while cnt<GUARD_CYCLES and DRIVE otherwise; there are no other states.
REQ-016 In GUARD, next o_anode SHALL be 4'b1111 and next o_7seg SHALL be 7'b1111111.
REQ-017 In DRIVE, next o_anode SHALL be all ones except bit dig, which is 0 when active_en[dig]=1 and the digit is not blink-blanked; next o_7seg SHALL be decode(active nibble dig).
REQ-018 When the digit is disabled or blink-blanked in DRIVE, o_anode SHALL be 4'b1111 and o_7seg SHALL be 7'b1111111, and the slot SHALL still take its full CLK_PER_DIGIT cycles.
REQ-019 o_anode and o_7seg SHALL be registered, giving exactly one cycle of latency from the (cnt, dig) state.
REQ-020 A scan wrap SHALL be the cycle where dig=3 and cnt=CLK_PER_DIGIT-1; o_scan_done SHALL be high on the following cycle only.
REQ-021 The scan counter SHALL increment on each wrap; when it reaches BLINK_SCANS-1 and a wrap occurs, it SHALL return to 0 and blink_phase SHALL toggle.
REQ-022 A digit SHALL be blink-blanked when blink_phase=1 and active_mask[dig]=1; blink_phase=0 means visible.
REQ-023 i_load SHALL write the inputs into pending registers and set the pending flag; if several loads occur before a wrap, the last one wins.
REQ-024 At a wrap with the pending flag set, pending SHALL copy to active, the flag SHALL clear, and o_load_ack SHALL pulse on the next cycle.
REQ-025 An i_load coinciding with a wrap SHALL be captured into pending and applied at the following wrap, not the current one.
REQ-026 Active values SHALL change only at scan wraps, so no digit changes content in mid-scan.

Reset
REQ-027 While i_rst=1 at a clock edge, the block SHALL clear cnt, dig, scan counter, blink_phase, the pending flag, and all pending and active registers to 0.
REQ-028 On that edge, o_anode SHALL become 4'b1111, o_7seg SHALL become 7'b1111111, and o_scan_done and o_load_ack SHALL become 0.
REQ-029 Reset asserted mid-slot or mid-load SHALL discard all pending data; the first cycle after reset release SHALL be cnt=0, dig=0 (GUARD).

Structure
REQ-030 The blank-segment constant 7'b1111111, the all-off anode constant and the digit count 4 SHALL live in a shared display package.
REQ-031 The block SHALL instantiate one led7_decoder, with i_en tied high, for segment encoding; blanking SHALL be done in this block.

Verification (CLK_PER_DIGIT=8, GUARD_CYCLES=2, BLINK_SCANS=2)
REQ-032 Hold i_rst=1 for 20 cycles -> o_anode=1111 and o_7seg=1111111 on every cycle, with no pulses on o_scan_done or o_load_ack.
REQ-033 Load 16'h1234, en=1111, mask=0000, then wait for the wrap -> o_load_ack pulses; the next slot gives 2 cycles of 1111, then 6 cycles of o_anode=1110 with o_7seg=0011001 ('4').
REQ-034 With en=1011 -> o_anode bit 2 never goes low, and the slot for digit 2 still lasts 8 cycles (32-cycle scan period).
REQ-035 mask=0001 -> digit 0 is shown for 2 scans, blanked for 2 scans, and the pattern repeats; digits 1-3 are unaffected.
REQ-036 i_load on the wrap cycle -> no o_load_ack 1 cycle later; o_load_ack appears 32 cycles later.
REQ-037 Assert i_rst at cnt=5, dig=2, with a load pending -> outputs blank; after release the scan restarts at digit 0 with active data all zero, and o_load_ack never fires.
